// File: rtl/spi_xfer_master.sv
// SPI mode-0 master shift engine: one full-duplex DATA_W-bit transfer per accepted start, MSB first.
// Optional active-low chip select output cs_n is built when SPI_CS_EN is defined.
module spi_xfer_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_data
`ifdef SPI_CS_EN
    ,
    output logic              cs_n
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic                sck_q, sck_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                valid_q, valid_d;
`ifdef SPI_CS_EN
    logic                cs_n_q, cs_n_d;
`endif

    // mosi is the MSB of the transmit register, so it holds its last bit while idle
    assign mosi       = tx_sr_q[DATA_W-1];
    assign sck        = sck_q;
    assign busy       = busy_q;
    assign data_out   = data_out_q;
    assign valid_data = valid_q;
`ifdef SPI_CS_EN
    assign cs_n       = cs_n_q;
`endif

    // Next-state and next-output logic for the transfer sequencer
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        sck_d      = sck_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                sck_d = 1'b0;
                if (start) begin
                    state_d   = SHIFT;
                    tx_sr_d   = data_in;
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sck_d     = ~sck_q;
                    if (!sck_q) begin
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        // Last falling edge: publish the word now so it is visible in DONE
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d    = DONE;
                            data_out_d = rx_sr_q;
                            valid_d    = 1'b1;
                        end else begin
                            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                sck_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                sck_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
`ifdef SPI_CS_EN
        cs_n_d = ~busy_d;
`endif
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            sck_q      <= 1'b0;
            busy_q     <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
`ifdef SPI_CS_EN
            cs_n_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            sck_q      <= sck_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
`ifdef SPI_CS_EN
            cs_n_q     <= cs_n_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_xfer_master.sv
// Bench for spi_xfer_master: two instances (CLK_DIV=2 and CLK_DIV=1) against a cycle-position model.
// Directed scenarios pin literal results; a randomized phase exercises data, miso patterns and resets.
module tb_spi_xfer_master;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic [7:0] data_in;
    logic [1:0] miso_mode;
    logic       miso_rnd;
    logic       chk_en;

    logic       mosi0, sck0, busy0, valid0, miso0;
    logic       mosi1, sck1, busy1, valid1, miso1;
    logic [7:0] dout0, dout1;
`ifdef SPI_CS_EN
    logic       cs0, cs1;
`endif

    function automatic logic pick(input logic [1:0] m, input logic lb, input logic r);
        case (m)
            2'd0:    return lb;
            2'd1:    return 1'b1;
            2'd2:    return 1'b0;
            default: return r;
        endcase
    endfunction

    assign miso0 = pick(miso_mode, mosi0, miso_rnd);
    assign miso1 = pick(miso_mode, mosi1, miso_rnd);

    spi_xfer_master #(.DATA_W(DW), .CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .miso(miso0),
        .mosi(mosi0), .sck(sck0), .busy(busy0), .data_out(dout0), .valid_data(valid0)
`ifdef SPI_CS_EN
        , .cs_n(cs0)
`endif
    );

    spi_xfer_master #(.DATA_W(DW), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .miso(miso1),
        .mosi(mosi1), .sck(sck1), .busy(busy1), .data_out(dout1), .valid_data(valid1)
`ifdef SPI_CS_EN
        , .cs_n(cs1)
`endif
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: per instance, t = position inside the transfer (0 = idle, 1..T busy, T = done cycle)
    int         cdv[2] = '{2, 1};
    int         t[2];
    logic [7:0] w[2], rx[2], dm[2];
    logic       lm[2];
    int         cyc = 0;

    initial begin
        logic mi[2];
        int   tt, p;
        forever begin
            @(posedge clk);
            cyc++;
            mi[0] = miso0;
            mi[1] = miso1;
            for (int k = 0; k < 2; k++) begin
                tt = 2 * DW * cdv[k] + 1;
                if (!rst) begin
                    t[k] = 0; rx[k] = 8'h00; dm[k] = 8'h00; lm[k] = 1'b0;
                end else if (t[k] == 0) begin
                    if (start) begin
                        t[k] = 1; w[k] = data_in; rx[k] = 8'h00;
                    end
                end else if (t[k] < tt) begin
                    p = (t[k] - 1) % (2 * cdv[k]);
                    if (p == cdv[k] - 1) rx[k] = {rx[k][6:0], mi[k]};
                    if (t[k] == tt - 1) dm[k] = rx[k];
                    t[k]++;
                end else begin
                    t[k] = 0;
                    lm[k] = w[k][0];
                end
            end
        end
    end

    task automatic cmp(input int k, input logic mo, input logic sc, input logic bu,
                       input logic va, input logic [7:0] dd);
        int   tt, p, b;
        logic e_mo, e_sc;
        tt = 2 * DW * cdv[k] + 1;
        if (t[k] == 0) begin
            e_mo = lm[k]; e_sc = 1'b0;
        end else if (t[k] < tt) begin
            p = (t[k] - 1) % (2 * cdv[k]);
            b = (t[k] - 1) / (2 * cdv[k]);
            e_sc = (p >= cdv[k]);
            e_mo = w[k][DW-1-b];
        end else begin
            e_mo = w[k][0]; e_sc = 1'b0;
        end
        chk($sformatf("mosi%0d", k),  32'(mo), 32'(e_mo));
        chk($sformatf("sck%0d", k),   32'(sc), 32'(e_sc));
        chk($sformatf("busy%0d", k),  32'(bu), 32'(t[k] != 0));
        chk($sformatf("valid%0d", k), 32'(va), 32'(t[k] == tt));
        chk($sformatf("dout%0d", k),  32'(dd), 32'(dm[k]));
    endtask

    // Event monitors used by the directed literal checks
    int         base = 0;
    int         bcnt[2], bfirst[2], blast[2], vcnt[2], vrel[2], rise[2];
    logic [7:0] rbits[2];
    logic       psck[2] = '{1'b0, 1'b0};
    logic [7:0] vq0[$], vq1[$];

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            bcnt[k] = 0; bfirst[k] = 0; blast[k] = 0; vcnt[k] = 0; vrel[k] = 0;
            rise[k] = 0; rbits[k] = 8'h00;
        end
        vq0.delete();
        vq1.delete();
    endtask

    task automatic mon(input int k, input logic mo, input logic sc, input logic bu,
                       input logic va, input logic [7:0] dd);
        if (bu) begin
            bcnt[k]++;
            if (bfirst[k] == 0) bfirst[k] = cyc - base;
            blast[k] = cyc - base;
        end
        if (va) begin
            vcnt[k]++;
            vrel[k] = cyc - base;
            if (k == 0) vq0.push_back(dd);
            else vq1.push_back(dd);
        end
        if (sc && !psck[k]) begin
            rise[k]++;
            rbits[k] = {rbits[k][6:0], mo};
        end
        psck[k] = sc;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp(0, mosi0, sck0, busy0, valid0, dout0);
                cmp(1, mosi1, sck1, busy1, valid1, dout1);
`ifdef SPI_CS_EN
                chk("cs_n0", 32'(cs0), 32'(t[0] == 0));
                chk("cs_n1", 32'(cs1), 32'(t[1] == 0));
`endif
                mon(0, mosi0, sck0, busy0, valid0, dout0);
                mon(1, mosi1, sck1, busy1, valid1, dout1);
            end
            miso_rnd = 1'($urandom_range(0, 1));
        end
    end

    task automatic kick(input logic [7:0] d);
        clr();
        base    = cyc;
        start   = 1'b1;
        data_in = d;
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy0 || busy1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 300), 32'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; data_in = 8'h00; miso_mode = 2'd0; miso_rnd = 1'b0;
        chk_en = 1'b0;
        clr();
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_sck",  32'(sck0),  32'd0);
        chk("rst_mosi", 32'(mosi0), 32'd0);
        chk("rst_dout", 32'(dout0), 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
`ifdef SPI_CS_EN
        chk("rst_cs_n", 32'(cs0), 32'd1);
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1: loopback 0xA5
        miso_mode = 2'd0;
        kick(8'hA5);
        repeat (40) @(negedge clk);
        chk("s1_busy_first", 32'(bfirst[0]), 32'd1);
        chk("s1_busy_last",  32'(blast[0]),  32'd33);
        chk("s1_busy_cnt",   32'(bcnt[0]),   32'd33);
        chk("s1_valid_cnt",  32'(vcnt[0]),   32'd1);
        chk("s1_valid_rel",  32'(vrel[0]),   32'd33);
        chk("s1_dout",       32'(dout0),     32'hA5);
        chk("s1_rises",      32'(rise[0]),   32'd8);
        chk("s1_mosi_bits",  32'(rbits[0]),  32'hA5);
        chk("s1_model_word", 32'(dm[0]),     32'hA5);
        chk("s1_d1_busy_last", 32'(blast[1]), 32'd17);
        chk("s1_d1_dout",    32'(dout1),     32'hA5);

        // Scenario 2: miso tied high then low
        miso_mode = 2'd1;
        kick(8'h00);
        repeat (40) @(negedge clk);
        chk("s2_ones0", 32'(dout0), 32'hFF);
        chk("s2_ones1", 32'(dout1), 32'hFF);
        miso_mode = 2'd2;
        kick(8'h00);
        repeat (40) @(negedge clk);
        chk("s2_zeros0", 32'(dout0), 32'h00);
        chk("s2_zeros1", 32'(dout1), 32'h00);

        // Scenario 3: start during a transfer is ignored
        miso_mode = 2'd0;
        kick(8'h3C);
        repeat (9) @(negedge clk);
        start = 1'b1; data_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("s3_vcnt0", 32'(vcnt[0]), 32'd1);
        chk("s3_dout0", 32'(dout0), 32'h3C);
        chk("s3_vcnt1", 32'(vcnt[1]), 32'd1);
        chk("s3_dout1", 32'(dout1), 32'h3C);

        // Scenario 4: reset at cycle 15 aborts, then a fresh transfer completes
        kick(8'h5A);
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("s4_sck",  32'(sck0),  32'd0);
        chk("s4_mosi", 32'(mosi0), 32'd0);
        chk("s4_busy", 32'(busy0), 32'd0);
        chk("s4_dout", 32'(dout0), 32'd0);
        chk("s4_busy1", 32'(busy1), 32'd0);
        repeat (40) @(negedge clk);
        chk("s4_novalid0", 32'(vcnt[0]), 32'd0);
        chk("s4_novalid1", 32'(vcnt[1]), 32'd0);
        kick(8'h96);
        repeat (40) @(negedge clk);
        chk("s4_after0", 32'(dout0), 32'h96);
        chk("s4_after1", 32'(dout1), 32'h96);

        // Scenario 5: start held high, back-to-back transfers
        clr();
        base = cyc;
        start = 1'b1; data_in = 8'h81;
        @(negedge clk);
        data_in = 8'h7E;
        repeat (34) @(negedge clk);
        start = 1'b0;
        repeat (80) @(negedge clk);
        chk("s5_n0", 32'(vq0.size()), 32'd2);
        chk("s5_n1", 32'(vq1.size()), 32'd2);
        if (vq0.size() == 2) begin
            chk("s5_d0a", 32'(vq0[0]), 32'h81);
            chk("s5_d0b", 32'(vq0[1]), 32'h7E);
        end
        if (vq1.size() == 2) begin
            chk("s5_d1a", 32'(vq1[0]), 32'h81);
            chk("s5_d1b", 32'(vq1[1]), 32'h7E);
        end
        chk("s5_busy0", 32'(bcnt[0]), 32'd66);
        chk("s5_busy1", 32'(bcnt[1]), 32'd34);

        // Randomized phase
        for (int i = 0; i < 40; i++) begin
            miso_mode = 2'($urandom_range(0, 3));
            kick(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                start = 1'b1; data_in = 8'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/spi_xfer_master.md
Name: spi_xfer_master

Overview:
SPI master shift engine that sits downstream of the TOP_spi data source. It takes a DATA_W-bit word plus a start strobe, runs one full-duplex SPI mode-0 transfer, MSB first, on mosi/sck, and captures miso. It reports busy during the transfer and pulses valid_data with the received word when the transfer completes.

Parameters:
DATA_W, 8, word width in bits; must be >= 2.
CLK_DIV, 2, sck half-period in clk cycles; must be >= 1, so sck = clk/(2*CLK_DIV).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-low reset.
start  input  1  transfer request; sampled only in IDLE.
data_in  input  DATA_W  word to transmit; latched on an accepted start.
miso  input  1  serial data from slave.
mosi  output  1  serial data to slave.
sck  output  1  SPI clock; idles low (CPOL=0).
busy  output  1  high from the cycle after an accepted start through the DONE cycle.
data_out  output  DATA_W  last received word; holds its value until the next completion.
valid_data  output  1  one-cycle pulse when data_out is updated.

Behaviour:
- Reset (rst=0 at a clk edge) sets state=IDLE, mosi=0, sck=0, busy=0, data_out=0, valid_data=0, and clears the divider, bit counter and shift registers. Reset mid-transfer aborts the transfer: no valid_data pulse, data_out=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1, load tx_sr<=data_in, clear rx_sr, bit_cnt and div_cnt, and go to SHIFT. mosi=data_in[DATA_W-1] and busy=1 from the next cycle. If start=0, stay in IDLE with sck=0 and mosi holding its last value.
- SHIFT: div_cnt counts 0..CLK_DIV-1. At terminal count, sck toggles and div_cnt wraps to 0.
  - sck rising (0->1): sample miso into rx_sr LSB (rx_sr<={rx_sr[DATA_W-2:0],miso}).
  - sck falling (1->0): bit_cnt increments. If bit_cnt was DATA_W-1, go to DONE. Otherwise shift tx_sr left, and mosi takes the next bit.
  - Mode 0 timing: mosi is stable for the full CLK_DIV cycles before each rising edge.
- DONE: lasts exactly one cycle. data_out<=rx_sr, valid_data=1, busy=1, sck=0. Next state is IDLE.
- Transfer latency: accepted start at edge 0 gives busy=1 for cycles 1..2*DATA_W*CLK_DIV+1. valid_data is high in the last of those cycles. busy=0 on the following cycle.
- Exactly DATA_W sck rising edges occur per transfer.
- start is ignored while in SHIFT or DONE; there is no queuing.
- If start is held high, a new transfer begins on the first IDLE cycle. This gives one idle cycle between transfers, with busy=0 for exactly 1 cycle.
- data_in changes after acceptance have no effect on the current transfer.
- valid_data is never high for two consecutive cycles.

Optional Feature:
Macro SPI_CS_EN.
- Defined: adds output port cs_n (1 bit, active-low chip select). cs_n=1 at reset and in IDLE; cs_n=0 in SHIFT and DONE, i.e. exactly while busy=1. After a reset mid-transfer, cs_n=1 on the next cycle.
- Undefined: no cs_n port and no related logic. All other behaviour is identical.

Test Plan:
1. Loopback (DATA_W=8, CLK_DIV=2, miso=mosi), data_in=0xA5, 1-cycle start -> busy high cycles 1..33, 8 sck rising edges, mosi bit sequence 1,0,1,0,0,1,0,1, valid_data high only at cycle 33 with data_out=0xA5, busy=0 at cycle 34.
2. miso tied 1, data_in=0x00 -> data_out=0xFF at valid_data. Then miso tied 0 -> data_out=0x00 on the next transfer.
3. Transfer 0x3C started; at cycle 10 assert start with data_in=0xFF -> ignored: loopback result is 0x3C and only one valid_data pulse occurs.
4. rst=0 at cycle 15 of a transfer -> next cycle sck=0, mosi=0, busy=0, data_out=0, and no valid_data pulse. A new start then completes normally.
5. start held high, data_in=0x81 then 0x7E -> two transfers with busy low for exactly 1 cycle between them and results 0x81 then 0x7E (loopback). Repeat with CLK_DIV=1 -> busy lasts 17 cycles per transfer.
6. SPI_CS_EN defined -> cs_n=1 after reset, cs_n=0 exactly when busy=1 in scenarios 1 and 4. Build without the macro -> port absent and scenario 1 passes unchanged.
